spi_txn_arbiter: RTL and testbench

- Shares the single `spi` top (controller + 32-byte memory) between NREQ independent requesters using round-robin arbitration.
- The `spi` block runs continuously: it loads `addr`/`wr`/`din` on every pass through its idle/load states, whether or not anyone is requesting.
- This arbiter therefore keeps a harmless "null" transaction on the bus when idle.
- It switches bus fields only on `spi_done` boundaries and returns each requester its read data, error and completion.

---
 rtl/spi_txn_arbiter.sv | 155 +++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one spi controller + memory among NREQ users.
// Holds a null (out-of-range) transaction on the bus whenever idle.
module spi_txn_arbiter #(
  parameter int         NREQ        = 4,
  parameter logic [7:0] NULL_ADDR   = 8'hFF,
  parameter int         TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*8-1:0] req_addr,
  input  logic [NREQ*8-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [7:0]        spi_addr,
  output logic              spi_wr,
  output logic [7:0]        spi_din,
  input  logic [7:0]        spi_dout,
  input  logic              spi_err,
  input  logic              spi_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SLOT,
    BUSY
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_ptr_nxt;
  logic            w_hit;
  logic            w_to;
  logic [WW-1:0]   r_wd;
  logic            r_wr;
  logic [7:0]      r_addr;
  logic [7:0]      r_din;
  logic [NREQ-1:0] w_one;

  assign w_one     = {{(NREQ-1){1'b0}}, 1'b1};
  assign w_to      = (r_wd == WW'(TIMEOUT_CYC - 1));
  assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + IW'(1);

  // Scan from the far end so the slot nearest r_ptr is written last and wins.
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) begin
        w_hit = 1'b1;
        w_win = IW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_hit) w_nxt = SLOT;
      SLOT: begin
        if (spi_done)  w_nxt = BUSY;
        else if (w_to) w_nxt = IDLE;
      end
      BUSY: if (spi_done || w_to) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      spi_addr    <= NULL_ADDR;
      spi_wr      <= 1'b0;
      spi_din     <= '0;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_wd        <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      gnt <= '0;
      ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_idx  <= w_win;
            r_wr   <= req_wr[w_win];
            r_addr <= req_addr[8*w_win +: 8];
            r_din  <= req_din[8*w_win +: 8];
            gnt    <= w_one << w_win;
            r_ptr  <= w_ptr_nxt;
            r_wd   <= '0;
          end
        end
        SLOT: begin
          // Null transaction just ended: spi loads our fields next pass.
          if (spi_done) begin
            spi_addr <= r_addr;
            spi_wr   <= r_wr;
            spi_din  <= r_din;
            r_wd     <= '0;
          end else if (w_to) begin
            ack         <= w_one << r_idx;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        BUSY: begin
          if (spi_done) begin
            if (!r_wr) rdata <= spi_dout;
            rsp_err     <= spi_err;
            rsp_timeout <= 1'b0;
            ack         <= w_one << r_idx;
            spi_addr    <= NULL_ADDR;
            spi_wr      <= 1'b0;
            spi_din     <= '0;
          end else if (w_to) begin
            ack         <= w_one << r_idx;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            spi_addr    <= NULL_ADDR;
            spi_wr      <= 1'b0;
            spi_din     <= '0;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural spi stub plus a scoreboard of
// expected grant order, memory contents and responses.
module tb_spi_txn_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_wr = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_din = '0;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  spi_addr;
  logic        spi_wr;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout = '0;
  logic        spi_err = 1'b0;
  logic        spi_done = 1'b0;

  spi_txn_arbiter #(
    .NREQ(4),
    .NULL_ADDR(8'hFF),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_din(req_din),
    .gnt(gnt),
    .ack(ack),
    .rdata(rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .spi_addr(spi_addr),
    .spi_wr(spi_wr),
    .spi_din(spi_din),
    .spi_dout(spi_dout),
    .spi_err(spi_err),
    .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  // spi stub: load, run a random number of cycles, one-cycle done, one
  // cycle gap, then load again with whatever fields are on the bus.
  int         m_ph = 0;
  int         m_lat = 0;
  logic [7:0] m_addr = '0;
  logic [7:0] m_din = '0;
  logic       m_wr = 1'b0;
  logic [7:0] mem [32];
  bit         stall = 1'b0;

  always @(posedge clk) begin
    spi_done <= 1'b0;
    if (!stall) begin
      if (m_ph == 0) begin
        m_addr <= spi_addr;
        m_wr   <= spi_wr;
        m_din  <= spi_din;
        m_lat  <= $urandom_range(1, 5);
        m_ph   <= 1;
      end else if (m_ph == 1) begin
        if (m_lat > 0) begin
          m_lat <= m_lat - 1;
        end else begin
          spi_done <= 1'b1;
          spi_err  <= (m_addr >= 8'd32);
          spi_dout <= (m_addr < 8'd32) ? mem[m_addr[4:0]] : 8'h00;
          if (m_wr && m_addr < 8'd32) mem[m_addr[4:0]] <= m_din;
          m_ph <= 2;
        end
      end else begin
        m_ph <= 0;
      end
    end
  end

  logic [7:0] ref_mem [32];
  logic [7:0] exp_rdata = '0;
  int         mptr = 0;
  bit         f_wr [4];
  logic [7:0] f_addr [4];
  logic [7:0] f_din [4];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit wr, input logic [7:0] a,
                         input logic [7:0] d);
    f_wr[i]            = wr;
    f_addr[i]          = a;
    f_din[i]           = d;
    req_wr[i]          = wr;
    req_addr[8*i +: 8] = a;
    req_din[8*i +: 8]  = d;
    req[i]             = 1'b1;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Serve n grants; expected winner comes from the round-robin model.
  task automatic serve(input bit hold, input int n);
    for (int t = 0; t < n; t++) begin
      int         w;
      int         c;
      logic [7:0] prev;
      w = pick(req, mptr);
      if (w < 0) break;
      c = 0;
      while (gnt == 4'd0 && c < 100) begin
        @(posedge clk); #1; c++;
      end
      chk("gnt", 32'(gnt), 32'(1) << w);
      if (!hold) req[w] = 1'b0;
      mptr = (w + 1) % N;
      c = 0;
      prev = spi_addr;
      while (ack == 4'd0 && c < 100) begin
        prev = spi_addr;
        @(posedge clk); #1; c++;
      end
      chk("ack", 32'(ack), 32'(1) << w);
      chk("bus_addr", 32'(prev), 32'(f_addr[w]));
      chk("rsp_err", 32'(rsp_err), 32'(f_addr[w] >= 8'd32));
      chk("rsp_timeout", 32'(rsp_timeout), 32'd0);
      if (!f_wr[w])
        exp_rdata = (f_addr[w] < 8'd32) ? ref_mem[f_addr[w][4:0]] : 8'h00;
      else if (f_addr[w] < 8'd32)
        ref_mem[f_addr[w][4:0]] = f_din[w];
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      chk("null_after_ack", 32'(spi_addr), 32'hFF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int         c;
    logic [3:0] anyack;
    logic [3:0] mask;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end

    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_spi_addr", 32'(spi_addr), 32'hFF);
    chk("rst_spi_wr", 32'(spi_wr), 32'd0);
    chk("rst_spi_din", 32'(spi_din), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    set_req(0, 1'b1, 8'd5, 8'hA5);
    serve(1'b0, 1);
    set_req(2, 1'b0, 8'd5, 8'h00);
    serve(1'b0, 1);
    chk("readback_a5", 32'(rdata), 32'hA5);

    set_req(1, 1'b1, 8'h40, 8'h3C);
    serve(1'b0, 1);
    set_req(3, 1'b0, 8'd0, 8'h00);
    serve(1'b0, 1);
    chk("oor_no_write", 32'(rdata), 32'd0);

    // Async reset while the granted read is in flight on the bus.
    set_req(2, 1'b0, 8'd3, 8'h00);
    c = 0;
    while (gnt == 4'd0 && c < 100) begin @(posedge clk); #1; c++; end
    chk("rstmid_gnt", 32'(gnt), 32'h4);
    c = 0;
    while (spi_addr != 8'd3 && c < 100) begin @(posedge clk); #1; c++; end
    chk("rstmid_busy", 32'(spi_addr), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_spi_addr", 32'(spi_addr), 32'hFF);
    chk("rstmid_gnt0", 32'(gnt), 32'd0);
    chk("rstmid_ack0", 32'(ack), 32'd0);
    chk("rstmid_rdata", 32'(rdata), 32'd0);
    exp_rdata = 8'h00;
    req = '0;
    mptr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    anyack = '0;
    repeat (30) begin @(posedge clk); #1; anyack |= ack; end
    chk("rstmid_no_ack", 32'(anyack), 32'd0);

    // All four held high: order must follow the rotating pointer from 0.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(i * 7), 8'h00);
    serve(1'b1, 5);
    req = '0;

    repeat (20) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (mask[i])
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 39)),
                  8'($urandom));
      serve(1'b0, $countones(mask));
    end

    stall = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    set_req(1, 1'b0, 8'd7, 8'h00);
    c = 0;
    while (gnt == 4'd0 && c < 100) begin @(posedge clk); #1; c++; end
    chk("to_gnt", 32'(gnt), 32'h2);
    req = '0;
    mptr = 2;
    c = 0;
    while (ack == 4'd0 && c < 100) begin @(posedge clk); #1; c++; end
    chk("to_cycles", 32'(c), 32'd16);
    chk("to_ack", 32'(ack), 32'h2);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_spi_addr", 32'(spi_addr), 32'hFF);
    stall = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
